mem_unit_dp: RTL and testbench
==============================

# mem_unit_dp

Parametrised unified instruction/data memory for the 32-bit RISC-V core, the successor to the fixed 2048-word memory. It has a fetch read port and a data load/store port with RV32 byte, half and word access, sign/zero extension and byte-lane writes. Misaligned and out-of-range accesses are reported as faults. On reset it runs a sequential clear sequence. It sits between the PC/fetch stage and the ALU/mem stage.

## Interface
- ADDR_W, 12, word-address width; byte addresses are ADDR_W+2 bits
- DEPTH, 2**ADDR_W, number of 32-bit words; must be ≤ 2**ADDR_W
- INIT_CLEAR, 1, 1 = zero every word after reset; 0 = skip the clear sequence
- clk  in  1  clock; all state updates on posedge
- I_rst_n  in  1  reset, synchronous and active-low
- O_ready  out  1  memory accepts requests (RUN state)
- I_if_en  in  1  fetch request
- I_if_addr  in  ADDR_W+2  fetch byte address
- O_if_data  out  32  fetched word
- O_if_valid  out  1  fetch response strobe
- O_if_fault  out  1  fetch misaligned or out of range
- I_d_en  in  1  data request
- I_d_we  in  1  1 = store, 0 = load
- I_d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- I_d_unsigned  in  1  loads: zero-extend instead of sign-extend
- I_d_addr  in  ADDR_W+2  data byte address
- I_d_wdata  in  32  store data, right-aligned
- O_d_rdata  out  32  extended load data; 0 for stores and faults
- O_d_valid  out  1  data response strobe (load data or store ack)
- O_d_fault  out  1  data misaligned, illegal size, or out of range

## Operation
- States: CLEAR, RUN.
- Reset with I_rst_n=0 at an edge:
  - state goes to CLEAR (or RUN if INIT_CLEAR=0)
  - clear counter goes to 0
  - all outputs go to 0
- CLEAR:
  - each cycle writes 0 to mem[cnt] and increments cnt
  - after writing DEPTH-1, go to RUN
  - O_ready stays 0
  - requests on both ports are ignored: no valid, no write
- RUN:
  - O_ready=1
  - both ports accept one request per cycle, independently
- Word index = addr[ADDR_W+1:2]; lane = addr[1:0].
- Fetch faults when addr[1:0]≠0 or word index ≥ DEPTH.
- Data faults when any of these holds:
  - size=11
  - half with addr[0]=1
  - word with addr[1:0]≠0
  - word index ≥ DEPTH
- On a fault: no write, data 0, valid=1, fault=1.
- Load result:
  - byte = mem[idx] bits [8·lane+7:8·lane]
  - half = bits [16·lane[1]+15:16·lane[1]]
  - sign-extended, or zero-extended when I_d_unsigned=1
- Store writes only the addressed lanes:
  - byte: wdata[7:0] into lane
  - half: wdata[15:0] into lanes lane..lane+1
  - word: all four lanes
- Same-word fetch and store in one cycle: fetch returns the pre-store (old) word, i.e. read-first.
- A load in cycle N+1 after a store in cycle N sees the new data.

## Timing
- Request sampled at edge N; response registered at edge N, visible during cycle N+1.
- Valid and fault strobes are high for exactly one cycle per request.
- Data outputs hold their last value while valid=0 (0 after reset).
- Latency is 1 cycle for both ports, with no stalls in RUN.
- CLEAR lasts exactly DEPTH cycles after the first edge with I_rst_n=1; O_ready rises in the cycle after the last clear write.
- Reset asserted at any time, including mid-CLEAR or with responses pending:
  - pending responses are dropped (valid=0 next cycle)
  - the clear sequence restarts from word 0
- Counter width is ADDR_W+1 so that DEPTH=2**ADDR_W terminates without wrap.

## Structure
- Package mem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W
  - state encoding ST_CLEAR, ST_RUN
  - the DATA_W=32 constant
- One combinational sub-module, mem_lane_align, used once for loads and once for stores:
  - load side: lane extract and sign/zero extend
  - store side: byte-enable generation and wdata shift
- Top holds the memory array, the FSM, the clear counter and the response registers.

## Test plan
- Reset and clear, DEPTH=16, INIT_CLEAR=1:
  - O_ready low for 16 cycles after reset release, then high
  - fetch issued during CLEAR gives no O_if_valid
  - LW 0x3C after ready returns 0x00000000
- Extension (all responses one cycle later, fault=0):
  - stimulus: SW 0x876543A1 at 0x20
  - LB 0x20 returns 0xFFFFFFA1
  - LBU 0x21 returns 0x00000043
  - LH 0x22 returns 0xFFFF8765
  - LHU 0x22 returns 0x00008765
- Byte-lane write:
  - stimulus: SB wdata=0x1234565A at 0x23 over 0x876543A1
  - LW 0x20 returns 0x5A6543A1
- Faults:
  - LH 0x21 gives fault=1, rdata=0
  - SW 0x22 gives fault=1, and LW 0x20 is unchanged
  - size=11 gives fault=1
  - LW 0x40 with DEPTH=16 gives fault=1
  - fetch 0x06 gives O_if_fault=1
- Read-first collision:
  - same cycle: fetch 0x20 and SW 0xDEADBEEF at 0x20
  - O_if_data returns 0x5A6543A1
  - the next fetch 0x20 returns 0xDEADBEEF
- Reset mid-operation:
  - assert I_rst_n=0 for 1 cycle with a load in flight
  - no O_d_valid the following cycle
  - O_ready low for 16 cycles
  - LW 0x20 then returns 0

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the unified instruction/data memory.
package mem_pkg;
  localparam int DATA_W    = 32;
  localparam int NUM_LANES = DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;
endpackage

// File: rtl/mem_unit_dp_if.sv
// Fetch and data port bundle between the core stages and mem_unit_dp.
interface mem_unit_dp_if import mem_pkg::*; #(
  parameter int ADDR_W = 12
) ();
  logic                O_ready;
  logic                I_if_en;
  logic [ADDR_W+1:0]   I_if_addr;
  logic [DATA_W-1:0]   O_if_data;
  logic                O_if_valid;
  logic                O_if_fault;
  logic                I_d_en;
  logic                I_d_we;
  logic [1:0]          I_d_size;
  logic                I_d_unsigned;
  logic [ADDR_W+1:0]   I_d_addr;
  logic [DATA_W-1:0]   I_d_wdata;
  logic [DATA_W-1:0]   O_d_rdata;
  logic                O_d_valid;
  logic                O_d_fault;

  modport slave (
    output O_ready, O_if_data, O_if_valid, O_if_fault,
           O_d_rdata, O_d_valid, O_d_fault,
    input  I_if_en, I_if_addr, I_d_en, I_d_we, I_d_size,
           I_d_unsigned, I_d_addr, I_d_wdata
  );

  modport master (
    input  O_ready, O_if_data, O_if_valid, O_if_fault,
           O_d_rdata, O_d_valid, O_d_fault,
    output I_if_en, I_if_addr, I_d_en, I_d_we, I_d_size,
           I_d_unsigned, I_d_addr, I_d_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: load extract/extend, or store shift plus byte enables.
module mem_lane_align import mem_pkg::*; (
  input  logic                 store,
  input  logic [1:0]           size,
  input  logic [1:0]           lane,
  input  logic                 is_unsigned,
  input  logic [DATA_W-1:0]    data_in,
  output logic [DATA_W-1:0]    data_out,
  output logic [NUM_LANES-1:0] be
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be       = '0;
    data_out = '0;
    byte_v   = data_in[{lane, 3'b000} +: 8];
    half_v   = data_in[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_B: begin
        be = NUM_LANES'(1) << lane;
        if (store) data_out = data_in << {lane, 3'b000};
        else       data_out = {{(DATA_W-8){~is_unsigned & byte_v[7]}}, byte_v};
      end
      SZ_H: begin
        be = NUM_LANES'(3) << {lane[1], 1'b0};
        if (store) data_out = data_in << {lane[1], 4'b0000};
        else       data_out = {{(DATA_W-16){~is_unsigned & half_v[15]}}, half_v};
      end
      SZ_W: begin
        be       = '1;
        data_out = data_in;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_unit_dp.sv
// Unified I/D memory: read-first fetch port, byte/half/word data port,
// fault reporting and a post-reset clear sweep.
module mem_unit_dp import mem_pkg::*; #(
  parameter int ADDR_W     = 12,
  parameter int DEPTH      = 2**ADDR_W,
  parameter int INIT_CLEAR = 1
) (
  input  logic          clk,
  input  logic          I_rst_n,
  mem_unit_dp_if.slave  bus
);
  localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST    = DEPTH_L - 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e               state;
  logic [ADDR_W:0]      cnt;
  logic                 ready, if_valid, if_fault, d_valid, d_fault;
  logic [DATA_W-1:0]    if_data, d_rdata;

  logic [ADDR_W-1:0]    if_idx, d_idx;
  logic                 if_bad, d_bad, run, clr_we, st_we;
  logic [DATA_W-1:0]    if_word, d_word, ld_data, st_data;
  logic [NUM_LANES-1:0] st_be, unused_ld_be;

  assign if_idx = bus.I_if_addr[ADDR_W+1:2];
  assign d_idx  = bus.I_d_addr[ADDR_W+1:2];
  assign run    = (state == ST_RUN);

  assign if_bad = (bus.I_if_addr[1:0] != 2'b00) || ({1'b0, if_idx} >= DEPTH_L);
  assign d_bad  = (bus.I_d_size == 2'b11)
               || (bus.I_d_size == SZ_H && bus.I_d_addr[0])
               || (bus.I_d_size == SZ_W && bus.I_d_addr[1:0] != 2'b00)
               || ({1'b0, d_idx} >= DEPTH_L);

  // Out-of-range indices alias here, but such accesses are faulted and never used.
  assign if_word = mem[if_idx[IW-1:0]];
  assign d_word  = mem[d_idx[IW-1:0]];

  mem_lane_align u_ld_align (
    .store       (1'b0),
    .size        (bus.I_d_size),
    .lane        (bus.I_d_addr[1:0]),
    .is_unsigned (bus.I_d_unsigned),
    .data_in     (d_word),
    .data_out    (ld_data),
    .be          (unused_ld_be)
  );

  mem_lane_align u_st_align (
    .store       (1'b1),
    .size        (bus.I_d_size),
    .lane        (bus.I_d_addr[1:0]),
    .is_unsigned (1'b0),
    .data_in     (bus.I_d_wdata),
    .data_out    (st_data),
    .be          (st_be)
  );

  assign clr_we = I_rst_n && (state == ST_CLEAR);
  assign st_we  = I_rst_n && run && bus.I_d_en && bus.I_d_we && !d_bad;

  // Fetch data is sampled from the same edge's pre-write contents: read-first.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt[IW-1:0]] <= '0;
    end else if (st_we) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (st_be[i]) mem[d_idx[IW-1:0]][8*i +: 8] <= st_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!I_rst_n) begin
      state    <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
      cnt      <= '0;
      ready    <= 1'b0;
      if_valid <= 1'b0;
      if_fault <= 1'b0;
      if_data  <= '0;
      d_valid  <= 1'b0;
      d_fault  <= 1'b0;
      d_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      if_fault <= 1'b0;
      d_valid  <= 1'b0;
      d_fault  <= 1'b0;
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          ready <= 1'b1;
          if (bus.I_if_en) begin
            if_valid <= 1'b1;
            if_fault <= if_bad;
            if_data  <= if_bad ? '0 : if_word;
          end
          if (bus.I_d_en) begin
            d_valid <= 1'b1;
            d_fault <= d_bad;
            d_rdata <= (d_bad || bus.I_d_we) ? '0 : ld_data;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  assign bus.O_ready    = ready;
  assign bus.O_if_data  = if_data;
  assign bus.O_if_valid = if_valid;
  assign bus.O_if_fault = if_fault;
  assign bus.O_d_rdata  = d_rdata;
  assign bus.O_d_valid  = d_valid;
  assign bus.O_d_fault  = d_fault;
endmodule

// File: tb/tb_mem_unit_dp.sv
// Scoreboard bench for mem_unit_dp with DEPTH=16 behind an 8-bit byte address.
module tb_mem_unit_dp;
  import mem_pkg::*;
  localparam int AW    = 6;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_unit_dp_if #(.ADDR_W(AW)) bus ();
  mem_unit_dp #(.ADDR_W(AW), .DEPTH(DEPTH), .INIT_CLEAR(1)) dut (
    .clk     (clk),
    .I_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        fault;
    string       name;
  } exp_t;

  exp_t dq[$];
  exp_t iq[$];
  int checks = 0, failures = 0, cyc = 0;

  always @(posedge clk) cyc++;

  // Responses must land exactly one cycle after the request, in order.
  always @(negedge clk) begin
    if (dq.size() > 0 && dq[0].due < cyc) begin
      checks++; failures++;
      $display("FAIL d_missing %s: no O_d_valid by cycle %0d", dq[0].name, dq[0].due);
      void'(dq.pop_front());
    end
    if (iq.size() > 0 && iq[0].due < cyc) begin
      checks++; failures++;
      $display("FAIL if_missing %s: no O_if_valid by cycle %0d", iq[0].name, iq[0].due);
      void'(iq.pop_front());
    end
    if (bus.O_d_valid === 1'b1) begin
      checks++;
      if (dq.size() == 0) begin
        failures++;
        $display("FAIL d_unexpected: got valid rdata=%h fault=%b at cycle %0d, required no response",
                 bus.O_d_rdata, bus.O_d_fault, cyc);
      end else begin
        exp_t e;
        e = dq.pop_front();
        if (e.due != cyc || bus.O_d_rdata !== e.data || bus.O_d_fault !== e.fault) begin
          failures++;
          $display("FAIL d_%s: got rdata=%h fault=%b cycle=%0d, required rdata=%h fault=%b cycle=%0d",
                   e.name, bus.O_d_rdata, bus.O_d_fault, cyc, e.data, e.fault, e.due);
        end
      end
    end
    if (bus.O_if_valid === 1'b1) begin
      checks++;
      if (iq.size() == 0) begin
        failures++;
        $display("FAIL if_unexpected: got valid data=%h fault=%b at cycle %0d, required no response",
                 bus.O_if_data, bus.O_if_fault, cyc);
      end else begin
        exp_t e;
        e = iq.pop_front();
        if (e.due != cyc || bus.O_if_data !== e.data || bus.O_if_fault !== e.fault) begin
          failures++;
          $display("FAIL if_%s: got data=%h fault=%b cycle=%0d, required data=%h fault=%b cycle=%0d",
                   e.name, bus.O_if_data, bus.O_if_fault, cyc, e.data, e.fault, e.due);
        end
      end
    end
  end

  task automatic idle();
    bus.I_if_en = 1'b0;
    bus.I_d_en  = 1'b0;
    bus.I_d_we  = 1'b0;
  endtask

  task automatic d_set(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [7:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_f, input string nm);
    bus.I_d_en = 1'b1; bus.I_d_we = we; bus.I_d_size = sz; bus.I_d_unsigned = uns;
    bus.I_d_addr = addr; bus.I_d_wdata = wd;
    dq.push_back('{cyc + 1, exp_d, exp_f, nm});
  endtask

  task automatic f_set(input logic [7:0] addr, input logic [31:0] exp_d,
                       input logic exp_f, input string nm);
    bus.I_if_en = 1'b1; bus.I_if_addr = addr;
    iq.push_back('{cyc + 1, exp_d, exp_f, nm});
  endtask

  task automatic test_reset();
    int n;
    n = 0;
    idle();
    bus.I_if_addr = '0; bus.I_d_addr = '0; bus.I_d_wdata = '0;
    bus.I_d_size = 2'b00; bus.I_d_unsigned = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.O_ready, bus.O_if_valid, bus.O_if_fault, bus.O_d_valid, bus.O_d_fault} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes: got ready/ifv/iff/dv/df=%b, required 00000",
               {bus.O_ready, bus.O_if_valid, bus.O_if_fault, bus.O_d_valid, bus.O_d_fault});
    end
    checks++;
    if (bus.O_d_rdata !== 32'h0 || bus.O_if_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: got rdata=%h if_data=%h, required 0 and 0", bus.O_d_rdata, bus.O_if_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Requests during the sweep must be ignored; the store lands on the final clear edge.
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.O_ready === 1'b1) break;
      if (n == 3) begin bus.I_if_en = 1'b1; bus.I_if_addr = 8'h00; end
      if (n == 6) bus.I_if_en = 1'b0;
      if (n == DEPTH - 1) begin
        bus.I_d_en = 1'b1; bus.I_d_we = 1'b1; bus.I_d_size = SZ_W;
        bus.I_d_addr = 8'h00; bus.I_d_wdata = 32'hFFFF_FFFF;
      end
    end
    idle();
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL clear_len: got O_ready rise after %0d cycles, required %0d", n, DEPTH);
    end
    @(negedge clk); d_set(1'b0, SZ_W, 1'b0, 8'h3C, 32'h0, 32'h0, 1'b0, "lw_3c_cleared");
    @(negedge clk); d_set(1'b0, SZ_W, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, "lw_00_no_clear_store");
    @(negedge clk); idle();
  endtask

  task automatic test_extension();
    @(negedge clk); d_set(1'b1, SZ_W, 1'b0, 8'h20, 32'h8765_43A1, 32'h0,         1'b0, "sw_20");
    @(negedge clk); d_set(1'b0, SZ_B, 1'b0, 8'h20, 32'h0,         32'hFFFF_FFA1, 1'b0, "lb_20");
    @(negedge clk); d_set(1'b0, SZ_B, 1'b1, 8'h21, 32'h0,         32'h0000_0043, 1'b0, "lbu_21");
    @(negedge clk); d_set(1'b0, SZ_B, 1'b0, 8'h21, 32'h0,         32'h0000_0043, 1'b0, "lb_21_pos");
    @(negedge clk); d_set(1'b0, SZ_B, 1'b1, 8'h23, 32'h0,         32'h0000_0087, 1'b0, "lbu_23");
    @(negedge clk); d_set(1'b0, SZ_H, 1'b0, 8'h22, 32'h0,         32'hFFFF_8765, 1'b0, "lh_22");
    @(negedge clk); d_set(1'b0, SZ_H, 1'b1, 8'h22, 32'h0,         32'h0000_8765, 1'b0, "lhu_22");
    @(negedge clk); d_set(1'b0, SZ_H, 1'b0, 8'h20, 32'h0,         32'h0000_43A1, 1'b0, "lh_20_pos");
    @(negedge clk); idle();
  endtask

  task automatic test_byte_lane();
    @(negedge clk); d_set(1'b1, SZ_B, 1'b0, 8'h23, 32'h1234_565A, 32'h0,         1'b0, "sb_23");
    @(negedge clk); d_set(1'b0, SZ_W, 1'b0, 8'h20, 32'h0,         32'h5A65_43A1, 1'b0, "lw_20_after_sb");
    @(negedge clk); d_set(1'b1, SZ_H, 1'b0, 8'h26, 32'hCAFE_BEEF, 32'h0,         1'b0, "sh_26");
    @(negedge clk); d_set(1'b0, SZ_W, 1'b0, 8'h24, 32'h0,         32'hBEEF_0000, 1'b0, "lw_24_after_sh");
    @(negedge clk); d_set(1'b0, SZ_H, 1'b1, 8'h26, 32'h0,         32'h0000_BEEF, 1'b0, "lhu_26");
    @(negedge clk); idle();
  endtask

  task automatic test_faults();
    @(negedge clk); d_set(1'b0, SZ_H,  1'b0, 8'h21, 32'h0,         32'h0,         1'b1, "lh_21_misalign");
    @(negedge clk); d_set(1'b1, SZ_W,  1'b0, 8'h22, 32'h1111_1111, 32'h0,         1'b1, "sw_22_misalign");
    @(negedge clk); d_set(1'b0, SZ_W,  1'b0, 8'h20, 32'h0,         32'h5A65_43A1, 1'b0, "lw_20_unchanged");
    @(negedge clk); d_set(1'b0, 2'b11, 1'b0, 8'h20, 32'h0,         32'h0,         1'b1, "ld_size11");
    @(negedge clk); d_set(1'b1, 2'b11, 1'b0, 8'h20, 32'h0,         32'h0,         1'b1, "st_size11");
    @(negedge clk); d_set(1'b0, SZ_W,  1'b0, 8'h40, 32'h0,         32'h0,         1'b1, "lw_40_range");
    f_set(8'h06, 32'h0, 1'b1, "fetch_06_misalign");
    @(negedge clk); d_set(1'b1, SZ_B,  1'b0, 8'h41, 32'h0000_00FF, 32'h0,         1'b1, "sb_41_range");
    f_set(8'h40, 32'h0, 1'b1, "fetch_40_range");
    @(negedge clk); d_set(1'b0, SZ_W,  1'b0, 8'h20, 32'h0,         32'h5A65_43A1, 1'b0, "lw_20_after_faults");
    f_set(8'h20, 32'h5A65_43A1, 1'b0, "fetch_20_ok");
    @(negedge clk); idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d_set(1'b1, SZ_W, 1'b0, 8'(4*i), 32'h1111_1111 * (i + 1), 32'h0, 1'b0, "b2b_sw");
      f_set(8'(4*i), 32'h0, 1'b0, "b2b_fetch_old");
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d_set(1'b0, SZ_W, 1'b0, 8'(4*i), 32'h0, 32'h1111_1111 * (i + 1), 1'b0, "b2b_lw");
      f_set(8'(4*i), 32'h1111_1111 * (i + 1), 1'b0, "b2b_fetch_new");
    end
    @(negedge clk); idle();
  endtask

  task automatic test_collision();
    @(negedge clk);
    d_set(1'b1, SZ_W, 1'b0, 8'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw_20_collide");
    f_set(8'h20, 32'h5A65_43A1, 1'b0, "fetch_20_read_first");
    @(negedge clk);
    d_set(1'b0, SZ_W, 1'b0, 8'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw_20_after_collide");
    f_set(8'h20, 32'hDEAD_BEEF, 1'b0, "fetch_20_new");
    @(negedge clk); idle();
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    @(negedge clk);
    d_set(1'b0, SZ_W, 1'b0, 8'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw_before_reset");
    @(negedge clk);
    // Second load and a fetch are presented on the reset edge and must vanish.
    bus.I_d_en = 1'b1; bus.I_d_we = 1'b0; bus.I_d_size = SZ_W; bus.I_d_addr = 8'h20;
    bus.I_if_en = 1'b1; bus.I_if_addr = 8'h20;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.O_d_valid !== 1'b0 || bus.O_if_valid !== 1'b0 || bus.O_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_drop: got dv=%b ifv=%b ready=%b, required 0 0 0",
               bus.O_d_valid, bus.O_if_valid, bus.O_ready);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.O_ready === 1'b1) break;
    end
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL reset_mid_clear_len: got O_ready rise after %0d cycles, required %0d", n, DEPTH);
    end
    @(negedge clk);
    d_set(1'b0, SZ_W, 1'b0, 8'h20, 32'h0, 32'h0, 1'b0, "lw_20_after_reset");
    f_set(8'h04, 32'h0, 1'b0, "fetch_04_after_reset");
    @(negedge clk); idle();
  endtask

  initial begin
    test_reset();
    test_extension();
    test_byte_lane();
    test_faults();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (dq.size() != 0 || iq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d data and %0d fetch responses outstanding, required 0 and 0",
               dq.size(), iq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion by 200000 time units, required completion");
    $fatal(1, "timeout");
  end
endmodule
